// File: rtl/muxn_pkg.sv
// rtl/muxn_pkg.sv - shared types for the N-channel registered mux
package muxn_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin find-first starting at ptr
module rr_pick #(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx
);

  int idx;

  // Scan from the far end back toward ptr so the last hit is the nearest one.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/muxn_rr_reg.sv
// rtl/muxn_rr_reg.sv - N-channel mux with registered output, fixed or round-robin select
module muxn_rr_reg
  import muxn_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N*WIDTH-1:0]   d,
  input  logic [N-1:0]         d_valid,
  output logic [N-1:0]         d_ready,
  output logic [WIDTH-1:0]     z,
  output logic                 z_valid,
  input  logic                 z_ready,
  output logic [SELW-1:0]      z_ch
);

  logic [WIDTH-1:0] z_q, z_d;
  logic             z_valid_q, z_valid_d;
  logic [SELW-1:0]  z_ch_q, z_ch_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             load;
  logic             fix_valid;
  logic             rr_valid;
  logic [SELW-1:0]  rr_idx;
  logic             gnt;
  logic [SELW-1:0]  gnt_idx;

  rr_pick #(.N(N)) u_pick (
    .req       (d_valid),
    .ptr       (ptr_q),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  always_comb begin
    load      = !z_valid_q || z_ready;
    fix_valid = 1'b0;
    // sel can exceed N-1 when N is not a power of two; that simply means no grant.
    if (int'(sel) < N) fix_valid = d_valid[sel];

    if (mux_mode_e'(mode) == MODE_RR) begin
      gnt     = rr_valid;
      gnt_idx = rr_idx;
    end else begin
      gnt     = fix_valid;
      gnt_idx = sel;
    end

    d_ready = '0;
    if (!rst && load && gnt) d_ready[gnt_idx] = 1'b1;

    z_d       = z_q;
    z_valid_d = z_valid_q;
    z_ch_d    = z_ch_q;
    ptr_d     = ptr_q;
    if (load) begin
      if (gnt) begin
        z_d       = d[int'(gnt_idx)*WIDTH +: WIDTH];
        z_ch_d    = gnt_idx;
        z_valid_d = 1'b1;
        if (mux_mode_e'(mode) == MODE_RR)
          ptr_d = (int'(gnt_idx) == N - 1) ? '0 : SELW'(gnt_idx + SELW'(1));
      end else begin
        z_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q       <= '0;
      z_valid_q <= 1'b0;
      z_ch_q    <= '0;
      ptr_q     <= '0;
    end else begin
      z_q       <= z_d;
      z_valid_q <= z_valid_d;
      z_ch_q    <= z_ch_d;
      ptr_q     <= ptr_d;
    end
  end

  assign z       = z_q;
  assign z_valid = z_valid_q;
  assign z_ch    = z_ch_q;

endmodule
